// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if: bundles the requester-side and multiplier-side signals
// of the shared-multiplier arbiter.
//   slave  : the arbiter's view.
//   master : the environment's view (requesters plus the multiplier).
// When MUL_SHARE_ARBITER_TIMEOUT_EN is defined, the interface also carries timeout_err.
interface mul_share_arbiter_if #(
   parameter int WORD_SIZE = 16,
   parameter int NUM_REQ   = 4,
   parameter int GRANT_W   = 2
) ();
   // Requester side
   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*WORD_SIZE-1:0] op_a;
   logic [NUM_REQ*WORD_SIZE-1:0] op_b;
   logic [NUM_REQ-1:0]           ack;
   logic [WORD_SIZE-1:0]         result;
   logic                         result_overflow;
   logic                         busy;
   logic [GRANT_W-1:0]           grant_idx;
   // Multiplier side
   logic [WORD_SIZE-1:0]         mul_operand1;
   logic [WORD_SIZE-1:0]         mul_operand2;
   logic                         mul_start;
   logic [WORD_SIZE-1:0]         mul_out;
   logic                         mul_overflow;
   logic                         mul_done;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
   logic                         timeout_err;
`endif

   modport slave (
      input  req, op_a, op_b, mul_out, mul_overflow, mul_done,
      output ack, result, result_overflow, busy, grant_idx,
             mul_operand1, mul_operand2, mul_start
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
      , output timeout_err
`endif
   );

   modport master (
      output req, op_a, op_b, mul_out, mul_overflow, mul_done,
      input  ack, result, result_overflow, busy, grant_idx,
             mul_operand1, mul_operand2, mul_start
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
      , input timeout_err
`endif
   );
endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one multi-cycle multiplier among
// NUM_REQ requesters.
// Each transaction follows the same sequence:
//   1. Grant one requester and latch its operands.
//   2. Pulse mul_start for one cycle.
//   3. Wait for mul_done.
//   4. Return the product with a one-cycle ack to the owner only.
// All outputs come straight from registers.
// Optional macro MUL_SHARE_ARBITER_TIMEOUT_EN enables a WAIT-state watchdog.
// The watchdog aborts with result=0, result_overflow=1 and timeout_err=1.
module mul_share_arbiter #(
   parameter int WORD_SIZE      = 16,
   parameter int NUM_REQ        = 4,
   parameter int GRANT_W        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst,
   mul_share_arbiter_if.slave  bus
);

   // Elaboration-time parameter sanity
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("mul_share_arbiter: NUM_REQ must be 2..8");
   end
   if (GRANT_W != $clog2(NUM_REQ)) begin : g_bad_grant_w
      $error("mul_share_arbiter: GRANT_W must equal ceil(log2(NUM_REQ))");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mul_share_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RESPOND = 2'd3
   } state_t;

   state_t               state_q,  state_d;
   logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [GRANT_W-1:0]   owner_q,  owner_d;
   logic [WORD_SIZE-1:0] a_q,      a_d;
   logic [WORD_SIZE-1:0] b_q,      b_d;
   logic [WORD_SIZE-1:0] result_q, result_d;
   logic                 ovf_q,    ovf_d;
   logic [NUM_REQ-1:0]   ack_q,    ack_d;
   logic                 start_q,  start_d;
   logic [GRANT_W:0]     pick_s;
   logic                 pick_valid_s;
   logic [GRANT_W-1:0]   pick_idx_s;
   logic [GRANT_W-1:0]   owner_next_s;

`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]     cnt_q,  cnt_d;
   logic                 tout_q, tout_d;
`endif

   // First set request at or above ptr, wrapping; MSB of the result flags "found".
   // The loop runs from the far end down so the closest candidate is written last.
   function automatic logic [GRANT_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [GRANT_W-1:0] ptr);
      logic [GRANT_W:0] r;
      int               idx;
      r = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (req[idx]) begin
            r = {1'b1, GRANT_W'(idx)};
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   assign pick_s       = rr_pick(bus.req, rr_ptr_q);
   assign pick_valid_s = pick_s[GRANT_W];
   assign pick_idx_s   = pick_s[GRANT_W-1:0];
   assign owner_next_s = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + GRANT_W'(1);

   // Next-state and next-output logic for the grant/issue/wait/respond sequence
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      ack_d    = '0;
      start_d  = 1'b0;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
      cnt_d    = cnt_q;
      tout_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_valid_s) begin
               owner_d = pick_idx_s;
               a_d     = bus.op_a[int'(pick_idx_s)*WORD_SIZE +: WORD_SIZE];
               b_d     = bus.op_b[int'(pick_idx_s)*WORD_SIZE +: WORD_SIZE];
               start_d = 1'b1;
               state_d = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            // A done in this cycle is ignored.
            state_d = S_WAIT;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            if (bus.mul_done) begin
               result_d = bus.mul_out;
               ovf_d    = bus.mul_overflow;
               ack_d    = NUM_REQ'(1) << owner_q;
               state_d  = S_RESPOND;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               result_d = '0;
               ovf_d    = 1'b1;
               tout_d   = 1'b1;
               ack_d    = NUM_REQ'(1) << owner_q;
               state_d  = S_RESPOND;
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
               state_d  = S_WAIT;
            end
`else
            end else begin
               state_d  = S_WAIT;
            end
`endif
         end
         S_RESPOND: begin
            // ack is high this cycle; the owner is ranked last next time.
            rr_ptr_d = owner_next_s;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset that drops any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         ack_q    <= '0;
         start_q  <= 1'b0;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
         cnt_q    <= '0;
         tout_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         ack_q    <= ack_d;
         start_q  <= start_d;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
         cnt_q    <= cnt_d;
         tout_q   <= tout_d;
`endif
      end
   end

   assign bus.ack             = ack_q;
   assign bus.result          = result_q;
   assign bus.result_overflow = ovf_q;
   assign bus.busy            = (state_q != S_IDLE);
   assign bus.grant_idx       = owner_q;
   assign bus.mul_operand1    = a_q;
   assign bus.mul_operand2    = b_q;
   assign bus.mul_start       = start_q;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
   assign bus.timeout_err     = tout_q;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter.
// Directed stimulus pushes hand-computed expectations into queues:
//   - expected multiplier starts (operands);
//   - expected acks (owner, result, overflow).
// A negedge monitor pops the queues and compares them against the DUT.
// With MUL_SHARE_ARBITER_TIMEOUT_EN defined, the watchdog case is also run.
module tb_mul_share_arbiter;
   localparam int W  = 16;
   localparam int N  = 4;
   localparam int GW = 2;

   typedef struct {
      int         idx;
      logic [W-1:0] res;
      logic       ovf;
      logic       tout;
      logic       chk_lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   exp_t          sb_q[$];
   logic [31:0]   st_q[$];

   // multiplier model controls
   int            mul_delay = 4;
   bit            mul_en    = 1'b1;
   int            m_pend    = 0;
   logic          m_done    = 1'b0;
   logic          spur_done = 1'b0;
   int            done_cyc  = -10;
   logic [W-1:0]  m_a, m_b;
   logic [31:0]   prod;

   mul_share_arbiter_if #(.WORD_SIZE(W), .NUM_REQ(N), .GRANT_W(GW)) bus ();

   mul_share_arbiter #(
      .WORD_SIZE(W), .NUM_REQ(N), .GRANT_W(GW), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign bus.mul_done = m_done | spur_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Multiplier model: latches operands on start and answers after mul_delay cycles.
   initial begin
      bus.mul_out      = '0;
      bus.mul_overflow = 1'b0;
      forever begin
         @(negedge clk);
         m_done = 1'b0;
         if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
               prod             = m_a * m_b;
               bus.mul_out      = prod[W-1:0];
               bus.mul_overflow = |prod[31:W];
               m_done           = 1'b1;
               done_cyc         = cyc;
            end
         end else if (bus.mul_start && mul_en) begin
            m_a    = bus.mul_operand1;
            m_b    = bus.mul_operand2;
            m_pend = mul_delay;
         end
      end
   end

   // Monitor: compare every start and every ack against the scoreboards.
   initial begin
      exp_t        e;
      logic [31:0] s;
      forever begin
         @(negedge clk);
         if (bus.mul_start) begin
            if (st_q.size() == 0) begin
               check("unexpected_start", 32'd1, 32'd0);
            end else begin
               s = st_q.pop_front();
               check("start_operand1", 32'(bus.mul_operand1), 32'(s[31:16]));
               check("start_operand2", 32'(bus.mul_operand2), 32'(s[15:0]));
            end
         end
         if (bus.ack != '0) begin
            if (sb_q.size() == 0) begin
               check("unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("ack_onehot", 32'(bus.ack), 32'd1 << e.idx);
               check("result", 32'(bus.result), 32'(e.res));
               check("result_overflow", 32'(bus.result_overflow), 32'(e.ovf));
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
               check("timeout_err", 32'(bus.timeout_err), 32'(e.tout));
`endif
               if (e.chk_lat) check("ack_after_done", 32'(cyc), 32'(done_cyc + 1));
            end
         end
      end
   end

   task automatic request(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.op_a[i*W +: W] = a;
      bus.op_b[i*W +: W] = b;
      bus.req[i]         = 1'b1;
   endtask

   task automatic expect_ack(input int i, input logic [W-1:0] res, input logic ovf,
                             input logic tout, input logic lat);
      exp_t e;
      e.idx = i; e.res = res; e.ovf = ovf; e.tout = tout; e.chk_lat = lat;
      sb_q.push_back(e);
   endtask

   // Wait (bounded) for ack[i]; drop req[i] so it is low in the following cycle.
   task automatic wait_ack(input int i, input int budget, output int waited);
      waited = 0;
      while (waited < budget) begin
         @(negedge clk);
         waited++;
         if (bus.ack[i]) begin
            bus.req[i] = 1'b0;
            return;
         end
      end
      check("ack_wait_timeout", 32'(waited), 32'(budget + 1));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},      32'(bus.busy), 32'd0);
      check({tag, "_ack"},       32'(bus.ack), 32'd0);
      check({tag, "_result"},    32'(bus.result), 32'd0);
      check({tag, "_ovf"},       32'(bus.result_overflow), 32'd0);
      check({tag, "_grant_idx"}, 32'(bus.grant_idx), 32'd0);
      check({tag, "_mul_start"}, 32'(bus.mul_start), 32'd0);
      check({tag, "_operand1"},  32'(bus.mul_operand1), 32'd0);
      check({tag, "_operand2"},  32'(bus.mul_operand2), 32'd0);
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
      check({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
`endif
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "time limit");
   end

   // Directed test sequence
   initial begin
      int w;
      int reassert[N];
      int budget[N];
      int served;

      bus.req  = '0;
      bus.op_a = '0;
      bus.op_b = '0;
      rst      = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // Single requester 0: 3*5=15, 4-cycle multiplier
      mul_delay = 4;
      request(0, 16'd3, 16'd5);
      st_q.push_back({16'd3, 16'd5});
      expect_ack(0, 16'd15, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("start_one_cycle_after_req", 32'(bus.mul_start), 32'd1);
      check("grant_idx_single", 32'(bus.grant_idx), 32'd0);
      wait_ack(0, 20, w);
      @(negedge clk);
      check("busy_drops_after_ack", 32'(bus.busy), 32'd0);

      // Operand change during WAIT: requester 2, 7*2=14
      request(2, 16'd7, 16'd2);
      st_q.push_back({16'd7, 16'd2});
      expect_ack(2, 16'd14, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      bus.op_a[2*W +: W] = 16'd9;
      wait_ack(2, 20, w);
      @(negedge clk);

      // Spurious done in IDLE
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      check("spurious_done_busy", 32'(bus.busy), 32'd0);
      check("spurious_done_start", 32'(bus.mul_start), 32'd0);
      @(negedge clk);

      // Overflow: 300*300 = 90000 -> low 16 bits 24464, overflow 1
      mul_delay = 3;
      request(1, 16'd300, 16'd300);
      st_q.push_back({16'd300, 16'd300});
      expect_ack(1, 16'd24464, 1'b1, 1'b0, 1'b1);
      wait_ack(1, 20, w);
      @(negedge clk);

      // Reset in WAIT; the late done must not produce an ack
      mul_delay = 6;
      request(2, 16'd4, 16'd4);
      st_q.push_back({16'd4, 16'd4});
      repeat (3) @(negedge clk);
      check("busy_before_reset", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      bus.req[2] = 1'b0;
      check_all_zero("midreset");
      repeat (10) @(negedge clk);
      check("idle_after_late_done", 32'(bus.busy), 32'd0);

      // All requesting: rr_ptr back at 0 gives order 0,1,2,3,0,1
      mul_delay = 2;
      for (int i = 0; i < N; i++) begin
         bus.op_a[i*W +: W] = W'(i + 2);
         bus.op_b[i*W +: W] = W'(i + 10);
         reassert[i] = 0;
      end
      budget = '{1, 1, 0, 0};
      st_q.push_back({16'd2, 16'd10}); expect_ack(0, 16'd20, 1'b0, 1'b0, 1'b1);
      st_q.push_back({16'd3, 16'd11}); expect_ack(1, 16'd33, 1'b0, 1'b0, 1'b1);
      st_q.push_back({16'd4, 16'd12}); expect_ack(2, 16'd48, 1'b0, 1'b0, 1'b1);
      st_q.push_back({16'd5, 16'd13}); expect_ack(3, 16'd65, 1'b0, 1'b0, 1'b1);
      st_q.push_back({16'd2, 16'd10}); expect_ack(0, 16'd20, 1'b0, 1'b0, 1'b1);
      st_q.push_back({16'd3, 16'd11}); expect_ack(1, 16'd33, 1'b0, 1'b0, 1'b1);
      bus.req = 4'b1111;
      served  = 0;
      for (int c = 0; c < 400 && served < 6; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (reassert[i] > 0) begin
               reassert[i]--;
               if (reassert[i] == 0) bus.req[i] = 1'b1;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (bus.ack[i]) begin
               served++;
               bus.req[i] = 1'b0;
               if (budget[i] > 0) begin
                  budget[i]--;
                  reassert[i] = 2;
               end
            end
         end
      end
      check("all_req_served", 32'(served), 32'd6);
      repeat (2) @(negedge clk);

      // Minimum latency with a 1-cycle multiplier: 100*7=700, ack 3 cycles after req
      mul_delay = 1;
      request(3, 16'd100, 16'd7);
      st_q.push_back({16'd100, 16'd7});
      expect_ack(3, 16'd700, 1'b0, 1'b0, 1'b1);
      wait_ack(3, 20, w);
      check("min_latency", 32'(w), 32'd3);
      @(negedge clk);

`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
      // Watchdog: no done; ack after 8 WAIT cycles (1 ISSUE + 8 WAIT + RESPOND)
      mul_en = 1'b0;
      request(0, 16'd5, 16'd5);
      st_q.push_back({16'd5, 16'd5});
      expect_ack(0, 16'd0, 1'b1, 1'b1, 1'b0);
      wait_ack(0, 40, w);
      check("timeout_latency", 32'(w), 32'd10);
      @(negedge clk);
      check("timeout_err_cleared", 32'(bus.timeout_err), 32'd0);
      mul_en = 1'b1;
`endif

      repeat (3) @(negedge clk);
      check("ack_queue_drained", 32'(sb_q.size()), 32'd0);
      check("start_queue_drained", 32'(st_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Round-robin arbiter that shares one multi-cycle multiplier (start/done handshake, e.g. multiplier_modified_booth) among NUM_REQ requesters in the ODE accelerator, such as the step module and solver stages.
- Latches the granted requester's operands, issues a one-cycle start, waits for done, then returns the product with a one-cycle ack to that requester only.

Parameters:
- WORD_SIZE, 16, operand/result width.
- NUM_REQ, 4, number of requesters (2..8).
- GRANT_W, 2, width of grant index; must equal ceil(log2(NUM_REQ)).
- TIMEOUT_CYCLES, 64, watchdog limit (used only with optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  request per requester; held until its ack.
- op_a  in  NUM_REQ*WORD_SIZE  flattened operand1; slice i = [i*WORD_SIZE +: WORD_SIZE].
- op_b  in  NUM_REQ*WORD_SIZE  flattened operand2, same slicing.
- ack  out  NUM_REQ  one-hot one-cycle completion pulse.
- result  out  WORD_SIZE  product; valid only in the ack cycle.
- result_overflow  out  1  multiplier overflow flag; valid in the ack cycle.
- busy  out  1  high in any state other than IDLE.
- grant_idx  out  GRANT_W  index of the current owner; valid while busy.
- mul_operand1  out  WORD_SIZE  to multiplier.
- mul_operand2  out  WORD_SIZE  to multiplier.
- mul_start  out  1  one-cycle start pulse to multiplier.
- mul_out  in  WORD_SIZE  multiplier product.
- mul_overflow  in  1  multiplier overflow.
- mul_done  in  1  multiplier completion.
- timeout_err  out  1  watchdog flag (exists only with optional feature).

Behaviour:
- Reset: synchronous, active-high; clk and rst named as elsewhere in the codebase.
  - state=IDLE, rr_ptr=0, owner=0.
  - Outputs after reset: ack=0, result=0, result_overflow=0, busy=0, grant_idx=0, mul_start=0, mul_operand1/2=0, timeout_err=0.
  - Reset mid-operation aborts immediately; no ack is issued, and the in-flight product is discarded.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr_ptr with wrap-around.
  - Latch owner=index, op_a slice into a_reg, op_b slice into b_reg; go to ISSUE.
  - If req=0, stay in IDLE.
- ISSUE:
  - mul_start=1 for exactly this cycle, with mul_operand1=a_reg and mul_operand2=b_reg.
  - Operand outputs stay driven from a_reg/b_reg through WAIT.
  - Next state: WAIT.
- WAIT:
  - On mul_done=1, register result=mul_out and result_overflow=mul_overflow; go to RESPOND.
  - A mul_done in the same cycle as ISSUE is ignored; mul_done in any other state is ignored.
- RESPOND:
  - ack[owner]=1 for one cycle, result held stable.
  - rr_ptr = owner+1, wrapping to 0 at NUM_REQ; next state IDLE.
- Requester rules:
  - A requester must deassert req in the cycle after its ack.
  - If req is still high in IDLE, it is treated as a new request but ranked after the other requesters by rr_ptr.
- Operand timing: operands are sampled only in the IDLE→ISSUE cycle; later changes do not affect the operation in flight.
- Latency: req seen in IDLE at cycle t gives mul_start at t+1 and ack at (cycle of mul_done)+1. Minimum request-to-ack with a 1-cycle multiplier is 3 cycles. Back-to-back grant gap is 1 IDLE cycle.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,2,…,NUM_REQ-1,0…; a requester waits at most NUM_REQ-1 services.
- req bits that rise while busy are held pending and are not dropped.
- ack for requester i never asserts unless req[i] was high at grant.

Optional Feature:
- Macro: MUL_SHARE_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mul_done, go to RESPOND with result=0, result_overflow=1, and timeout_err=1 in the ack cycle.
  - The timeout_err port exists.
- Undefined: no counter, no timeout_err port; WAIT lasts indefinitely until mul_done.

Test Plan:
- Single requester:
  - Stimulus: req=0001, op_a[0]=3, op_b[0]=5, model multiplier with 4-cycle done.
  - Response: mul_start one cycle after req, operands 3/5, ack=0001 with result=15 one cycle after mul_done; busy drops the cycle after.
- All requesting:
  - Stimulus: req=1111 held, each deasserted the cycle after its ack and reasserted 2 cycles later.
  - Response: grant order 0,1,2,3,0,1; acks one-hot, never overlapping.
- Operand change after grant:
  - Stimulus: op_a[2] changes from 7 to 9 during WAIT, op_b[2]=2.
  - Response: result=14.
- Reset mid-operation:
  - Stimulus: rst in WAIT; mul_done arrives after reset.
  - Response: no ack, state IDLE, all outputs 0, rr_ptr=0.
- Overflow and spurious done:
  - Stimulus: mul_done pulsed in IDLE; then a grant where mul_overflow=1.
  - Response: no action in IDLE; result_overflow=1 in the ack cycle.
- Timeout (feature on):
  - Stimulus: TIMEOUT_CYCLES=8, mul_done never asserts.
  - Response: ack after 8 WAIT cycles with result=0, result_overflow=1, timeout_err=1.
